lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store initiator for the byte-addressable data store. Sits between the CPU datapath and the memory port (str/mode/address/data_in/data_out).
- Accepts one access request at a time from the CPU over a valid/ready handshake. Checks alignment, drives the memory port for a programmable number of cycles, then returns sign- or zero-extended load data, or an error, over a valid/ready response handshake.

Parameters:
AWIDTH, 12, byte-address width of the memory port
DWIDTH, 32, data width (fixed 32; other values unsupported)
RD_LAT, 1, cycles the memory port is held per access (>=1); read data sampled on the last of these

Ports:
clk  in  1  clock, all logic on rising edge
clr_n  in  1  synchronous active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  unit can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 word, 01 byte, 10 half, 11 illegal (same encoding as memory mode)
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  AWIDTH  byte address
req_wdata  in  DWIDTH  store data, right-justified
resp_valid  out  1  response valid
resp_ready  in  1  CPU accepts response
resp_rdata  out  DWIDTH  extended load data; 0 for stores and errors
resp_err  out  1  misaligned address or illegal size
mem_str  out  1  memory write strobe
mem_mode  out  2  memory access mode
mem_addr  out  AWIDTH  memory byte address
mem_din  out  DWIDTH  memory write data, right-justified
mem_dout  in  DWIDTH  memory read data, right-justified, combinational from mem_addr/mem_mode

Behaviour:
- Reset (clr_n=0 at a rising edge) is synchronous and active-low.
  - State goes to IDLE; counter clears.
  - All outputs are registered and reset to 0: req_ready, resp_valid, resp_rdata, resp_err, mem_str, mem_mode, mem_addr, mem_din.
  - Reset mid-access aborts the access with no response. Any pending mem_str is dropped in the cycle after reset.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1.
  - A request is accepted on a rising edge with req_valid=1 and req_ready=1. The request fields are captured.
  - Error check: size=11, half with addr[0]=1, or word with addr[1:0]!=0.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. No memory cycle occurs; mem_str stays 0.
  - Otherwise: go to ACCESS. Load mem_addr, mem_mode=req_size, mem_din=req_wdata. Set mem_str=req_we. Load cnt=RD_LAT-1.
- ACCESS: req_ready=0. The mem_* outputs hold steady.
  - mem_str is high only in the first ACCESS cycle, so exactly one write per store.
  - While cnt!=0, decrement cnt.
  - When cnt==0: capture the response and go to RESP. Load data is extended from mem_dout. Store response is rdata=0, err=0.
- Load extension:
  - byte: bits 31:8 = unsigned ? 0 : mem_dout[7].
  - half: bits 31:16 = unsigned ? 0 : mem_dout[15].
  - word: passed through; req_unsigned is ignored.
- RESP: resp_valid=1; resp_rdata and resp_err held stable until resp_ready=1 at an edge. Then resp_valid=0, go to IDLE, and req_ready=1 on the next cycle.
  - No new request is accepted in RESP. Strict one-outstanding access.
- Latency (RD_LAT=1, resp_ready held 1):
  - accept at edge 0, ACCESS during cycle 1, resp_valid during cycle 2, next accept possible at edge 3.
  - Error path: resp_valid during cycle 1.
- In IDLE and RESP, mem_addr, mem_mode and mem_din keep their last values and mem_str=0.
- req_* inputs are ignored when req_ready=0.

Test Plan:
- Reset then store word: addr 0x010, wdata 0xDEADBEEF. Then load word from 0x010 -> exactly one mem_str pulse with mem_mode=00; load resp_rdata=0xDEADBEEF, resp_err=0.
- Byte loads with mem_dout=0x00000080: signed -> 0xFFFFFF80; unsigned -> 0x00000080.
- Half loads with mem_dout=0x0000F00D: signed -> 0xFFFFF00D; unsigned -> 0x0000F00D.
- Misaligned half at 0x003, word at 0x002, and size=11 -> resp_err=1, resp_rdata=0, mem_str never asserted, resp_valid one cycle after accept.
- RD_LAT=3 store: mem_str high for exactly 1 of 3 ACCESS cycles; mem_addr stable over all 3. resp_ready held 0 for 4 cycles -> resp_valid stays high and req_ready stays 0 throughout.
- clr_n pulsed low during ACCESS of a load -> next cycle all outputs 0, no resp_valid. A subsequent request completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store initiator: one outstanding CPU access, alignment check, a fixed
// RD_LAT-cycle memory port hold, and extended load data on a response handshake.
module lsu_ctrl #(
  parameter int AWIDTH = 12,
  parameter int DWIDTH = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DWIDTH-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_str,
  output logic [1:0]        mem_mode,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [1:0] MODE_WORD = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;
  localparam logic [1:0] MODE_HALF = 2'b10;
  localparam logic [1:0] MODE_ILL  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              r_state, w_state;
  logic [CW-1:0]       r_cnt, w_cnt;
  logic                r_we, w_we;
  logic                r_unsigned, w_unsigned;
  logic                r_req_ready, w_req_ready;
  logic                r_resp_valid, w_resp_valid;
  logic [DWIDTH-1:0]   r_resp_rdata, w_resp_rdata;
  logic                r_resp_err, w_resp_err;
  logic                r_mem_str, w_mem_str;
  logic [1:0]          r_mem_mode, w_mem_mode;
  logic [AWIDTH-1:0]   r_mem_addr, w_mem_addr;
  logic [DWIDTH-1:0]   r_mem_din, w_mem_din;
  logic                w_bad;
  logic [DWIDTH-1:0]   w_load_ext;

  assign w_bad = (req_size == MODE_ILL)
              || ((req_size == MODE_HALF) && req_addr[0])
              || ((req_size == MODE_WORD) && (req_addr[1:0] != 2'b00));

  // Extension uses the captured mode/signedness since the request bus is free during ACCESS.
  always_comb begin
    w_load_ext = mem_dout;
    case (r_mem_mode)
      MODE_BYTE: w_load_ext = {{(DWIDTH-8){mem_dout[7] & ~r_unsigned}}, mem_dout[7:0]};
      MODE_HALF: w_load_ext = {{(DWIDTH-16){mem_dout[15] & ~r_unsigned}}, mem_dout[15:0]};
      default:   w_load_ext = mem_dout;
    endcase
  end

  always_comb begin
    // NOTE: every next-value starts from a hold/default so no path leaves one unassigned (no latch).
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_we         = r_we;
    w_unsigned   = r_unsigned;
    w_req_ready  = r_req_ready;
    w_resp_valid = r_resp_valid;
    w_resp_rdata = r_resp_rdata;
    w_resp_err   = r_resp_err;
    w_mem_str    = 1'b0;
    w_mem_mode   = r_mem_mode;
    w_mem_addr   = r_mem_addr;
    w_mem_din    = r_mem_din;

    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid && r_req_ready) begin
          w_req_ready = 1'b0;
          if (w_bad) begin
            w_state      = S_RESP;
            w_resp_valid = 1'b1;
            w_resp_err   = 1'b1;
            w_resp_rdata = '0;
          end else begin
            w_state    = S_ACCESS;
            w_mem_addr = req_addr;
            w_mem_mode = req_size;
            w_mem_din  = req_wdata;
            w_mem_str  = req_we;
            w_we       = req_we;
            w_unsigned = req_unsigned;
            w_cnt      = CW'(RD_LAT - 1);
          end
        end
      end
      S_ACCESS: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - CW'(1);
        end else begin
          w_state      = S_RESP;
          w_resp_valid = 1'b1;
          w_resp_err   = 1'b0;
          w_resp_rdata = r_we ? '0 : w_load_ext;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state      = S_IDLE;
          w_resp_valid = 1'b0;
          w_req_ready  = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_str    <= 1'b0;
      r_mem_mode   <= '0;
      r_mem_addr   <= '0;
      r_mem_din    <= '0;
    end else begin
      // NOTE: non-blocking here so every register samples the pre-edge values.
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_we         <= w_we;
      r_unsigned   <= w_unsigned;
      r_req_ready  <= w_req_ready;
      r_resp_valid <= w_resp_valid;
      r_resp_rdata <= w_resp_rdata;
      r_resp_err   <= w_resp_err;
      r_mem_str    <= w_mem_str;
      r_mem_mode   <= w_mem_mode;
      r_mem_addr   <= w_mem_addr;
      r_mem_din    <= w_mem_din;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_str    = r_mem_str;
  assign mem_mode   = r_mem_mode;
  assign mem_addr   = r_mem_addr;
  assign mem_din    = r_mem_din;

endmodule
